// File: rtl/seg_execute_muldiv_ctrl.sv
// rtl/seg_execute_muldiv_ctrl.sv - multi-cycle MULT/DIV sequencer owning the HI/LO register pair
module seg_execute_muldiv_ctrl #(
  parameter int NB_DATA = 32,
  parameter int NB_FUNC = 6,
  parameter int NB_CNT  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_FUNC-1:0] i_funct,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic               i_flush,
  output logic               o_stall,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_zero,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam logic [NB_FUNC-1:0] FN_MFHI  = NB_FUNC'(6'b010000);
  localparam logic [NB_FUNC-1:0] FN_MTHI  = NB_FUNC'(6'b010001);
  localparam logic [NB_FUNC-1:0] FN_MFLO  = NB_FUNC'(6'b010010);
  localparam logic [NB_FUNC-1:0] FN_MTLO  = NB_FUNC'(6'b010011);
  localparam logic [NB_FUNC-1:0] FN_MULT  = NB_FUNC'(6'b011000);
  localparam logic [NB_FUNC-1:0] FN_MULTU = NB_FUNC'(6'b011001);
  localparam logic [NB_FUNC-1:0] FN_DIV   = NB_FUNC'(6'b011010);
  localparam logic [NB_FUNC-1:0] FN_DIVU  = NB_FUNC'(6'b011011);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Operation context latched at accept
  logic [NB_CNT-1:0]  r_cnt;
  logic [NB_DATA-1:0] r_acc_hi;   // multiply: accumulator upper / divide: remainder
  logic [NB_DATA-1:0] r_acc_lo;   // multiply: multiplier shifting out / divide: quotient
  logic [NB_DATA-1:0] r_opnd;     // multiplicand or divisor magnitude
  logic [NB_DATA-1:0] r_rs_orig;  // dividend as presented, returned in HI on divide-by-zero
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;

  logic               r_busy;
  logic               r_done;
  logic               r_dz_pulse;
  logic [NB_DATA-1:0] r_hi;
  logic [NB_DATA-1:0] r_lo;

  // Instruction decode
  logic w_is_muldiv;
  logic w_is_hilo;
  logic w_is_mthi;
  logic w_is_mtlo;
  logic w_is_div;
  logic w_is_signed;
  logic w_accept;
  logic w_mt_wr;
  logic w_fix_commit;

  assign w_is_muldiv = (i_funct == FN_MULT) | (i_funct == FN_MULTU) |
                       (i_funct == FN_DIV)  | (i_funct == FN_DIVU);
  assign w_is_mthi   = (i_funct == FN_MTHI);
  assign w_is_mtlo   = (i_funct == FN_MTLO);
  assign w_is_hilo   = w_is_muldiv | w_is_mthi | w_is_mtlo |
                       (i_funct == FN_MFHI) | (i_funct == FN_MFLO);
  assign w_is_div    = i_funct[1];
  assign w_is_signed = ~i_funct[0];

  assign w_accept     = (r_state == ST_IDLE) & i_valid & w_is_muldiv & ~i_flush;
  assign w_mt_wr      = (r_state == ST_IDLE) & i_valid & ~o_stall & ~i_flush &
                        (w_is_mthi | w_is_mtlo);
  assign w_fix_commit = (r_state == ST_FIX) & ~i_flush;

  // Operand magnitudes and signs for signed ops
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [NB_DATA-1:0] w_rs_mag;
  logic [NB_DATA-1:0] w_rt_mag;

  assign w_rs_neg = w_is_signed & i_rs_data[NB_DATA-1];
  assign w_rt_neg = w_is_signed & i_rt_data[NB_DATA-1];
  assign w_rs_mag = w_rs_neg ? (~i_rs_data + 1'b1) : i_rs_data;
  assign w_rt_mag = w_rt_neg ? (~i_rt_data + 1'b1) : i_rt_data;

  // One iteration of shift-add multiply or restoring divide
  logic [NB_DATA:0]   w_mul_sum;
  logic [NB_DATA:0]   w_mul_upper;
  logic [NB_DATA:0]   w_rem_sh;
  logic [NB_DATA-1:0] w_rem_sub;
  logic               w_rem_ge;
  logic [NB_DATA-1:0] w_step_hi;
  logic [NB_DATA-1:0] w_step_lo;

  assign w_mul_sum   = {1'b0, r_acc_hi} + {1'b0, r_opnd};
  assign w_mul_upper = r_acc_lo[0] ? w_mul_sum : {1'b0, r_acc_hi};
  assign w_rem_sh    = {r_acc_hi, r_acc_lo[NB_DATA-1]};
  assign w_rem_ge    = (w_rem_sh >= {1'b0, r_opnd});
  // Only used when the shifted remainder is >= divisor, so the difference fits NB_DATA bits
  assign w_rem_sub   = w_rem_sh[NB_DATA-1:0] - r_opnd;

  // Select the next accumulator value for the latched operation type
  always_comb begin
    w_step_hi = r_acc_hi;
    w_step_lo = r_acc_lo;
    if (r_is_div) begin
      w_step_hi = w_rem_ge ? w_rem_sub : w_rem_sh[NB_DATA-1:0];
      w_step_lo = {r_acc_lo[NB_DATA-2:0], w_rem_ge};
    end else begin
      w_step_hi = w_mul_upper[NB_DATA:1];
      w_step_lo = {w_mul_upper[0], r_acc_lo[NB_DATA-1:1]};
    end
  end

  // Sign correction and final HI/LO values
  logic [2*NB_DATA-1:0] w_prod;
  logic [2*NB_DATA-1:0] w_prod_fix;
  logic [NB_DATA-1:0]   w_quo_fix;
  logic [NB_DATA-1:0]   w_rem_fix;
  logic [NB_DATA-1:0]   w_hi_res;
  logic [NB_DATA-1:0]   w_lo_res;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = r_neg_q ? (~r_acc_lo + 1'b1) : r_acc_lo;
  assign w_rem_fix  = r_neg_r ? (~r_acc_hi + 1'b1) : r_acc_hi;

  // Pick product halves or remainder/quotient; divide-by-zero overrides both
  always_comb begin
    w_hi_res = w_prod_fix[2*NB_DATA-1:NB_DATA];
    w_lo_res = w_prod_fix[NB_DATA-1:0];
    if (r_is_div) begin
      if (r_div_zero) begin
        w_hi_res = r_rs_orig;
        w_lo_res = '1;
      end else begin
        w_hi_res = w_rem_fix;
        w_lo_res = w_quo_fix;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and HI/LO interlock
  always_comb begin
    w_state_nxt = r_state;
    o_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        o_stall = i_valid & w_is_hilo;
        if (i_flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == {NB_CNT{1'b1}}) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        o_stall     = i_valid & w_is_hilo;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch operands at accept, iterate the datapath while running
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opnd     <= '0;
      r_rs_orig  <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_is_div   <= w_is_div;
      r_neg_q    <= w_rs_neg ^ w_rt_neg;
      r_neg_r    <= w_rs_neg;
      r_div_zero <= w_is_div & (i_rt_data == '0);
      r_rs_orig  <= i_rs_data;
      r_acc_hi   <= '0;
      if (w_is_div) begin
        r_acc_lo <= w_rs_mag;
        r_opnd   <= w_rt_mag;
      end else begin
        r_acc_lo <= w_rt_mag;
        r_opnd   <= w_rs_mag;
      end
    end else if (r_state == ST_RUN) begin
      r_cnt    <= r_cnt + 1'b1;
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
    end
  end

  // HI/LO: mul/div results on commit, MTHI/MTLO writes when idle
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fix_commit) begin
      r_hi <= w_hi_res;
      r_lo <= w_lo_res;
    end else if (w_mt_wr) begin
      if (w_is_mthi) begin
        r_hi <= i_rs_data;
      end
      if (w_is_mtlo) begin
        r_lo <= i_rs_data;
      end
    end
  end

  // Busy flag and single-cycle completion pulses
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= w_fix_commit;
      r_dz_pulse <= w_fix_commit & r_is_div & r_div_zero;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_dz_pulse;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule
